// File: rtl/fruit_random_gen.sv
// fruit_random_gen: 16-bit Fibonacci LFSR feeding a small fill FSM that
// delivers four random fruit bytes at once to the fruit-type decoder.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetN     in   asynchronous reset, active HIGH despite the name
//   req        in   request a new set of four fruit bytes
//   seed_load  in   reload the LFSR from seed_in on the next edge
//   seed_in    in   [15:0] reseed value (zero is mapped to 16'h0001)
//   fruit1_t..fruit4_t  out  [7:0] registered fruit bytes, updated together
//   valid      out  one-cycle pulse after a complete set has loaded
//   busy       out  high while the four slots are being filled
module fruit_random_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  output logic [7:0]  fruit1_t,
  output logic [7:0]  fruit2_t,
  output logic [7:0]  fruit3_t,
  output logic [7:0]  fruit4_t,
  output logic        valid,
  output logic        busy
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  // An all-zero LFSR would lock up, so zero seeds are replaced by 1.
  localparam logic [LFSR_W-1:0] RESET_LFSR =
    (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [BYTE_W-1:0]   slot0_q, slot0_d;
  logic [BYTE_W-1:0]   slot1_q, slot1_d;
  logic [BYTE_W-1:0]   slot2_q, slot2_d;
  logic [BYTE_W-1:0]   fruit1_q, fruit1_d;
  logic [BYTE_W-1:0]   fruit2_q, fruit2_d;
  logic [BYTE_W-1:0]   fruit3_q, fruit3_d;
  logic [BYTE_W-1:0]   fruit4_q, fruit4_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                fb_c;

  // LFSR next value: reseed has priority over the free-running advance.
  always_comb begin
    fb_c   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = {lfsr_q[14:0], fb_c};
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? LFSR_W'(1) : seed_in;
    end
  end

  // Fill FSM next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    slot2_d  = slot2_q;
    fruit1_d = fruit1_q;
    fruit2_d = fruit2_q;
    fruit3_d = fruit3_q;
    fruit4_d = fruit4_q;
    case (state_q)
      IDLE: begin
        if (req || pend_q) begin
          state_d = FILL;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      FILL: begin
        if (req) pend_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // Capture the pre-advance byte; the last slot goes straight out
        // with the shadowed three so the set updates atomically.
        case (cnt_q)
          2'd0: slot0_d = lfsr_q[BYTE_W-1:0];
          2'd1: slot1_d = lfsr_q[BYTE_W-1:0];
          2'd2: slot2_d = lfsr_q[BYTE_W-1:0];
          default: begin
            fruit1_d = slot0_q;
            fruit2_d = slot1_q;
            fruit3_d = slot2_q;
            fruit4_d = lfsr_q[BYTE_W-1:0];
            state_d  = DONE;
          end
        endcase
      end
      DONE: begin
        if (req) pend_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == FILL);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q  <= IDLE;
      lfsr_q   <= RESET_LFSR;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      slot0_q  <= '0;
      slot1_q  <= '0;
      slot2_q  <= '0;
      fruit1_q <= '0;
      fruit2_q <= '0;
      fruit3_q <= '0;
      fruit4_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      slot2_q  <= slot2_d;
      fruit1_q <= fruit1_d;
      fruit2_q <= fruit2_d;
      fruit3_q <= fruit3_d;
      fruit4_q <= fruit4_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign fruit1_t = fruit1_q;
  assign fruit2_t = fruit2_q;
  assign fruit3_t = fruit3_q;
  assign fruit4_t = fruit4_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fruit_random_gen.sv
// Testbench for fruit_random_gen: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level model.
module tb_fruit_random_gen;

  logic        clk = 1'b0;
  logic        resetN;
  logic        req;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [7:0]  fruit1_t, fruit2_t, fruit3_t, fruit4_t;
  logic        valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase 0 = waiting, 1..4 = collecting byte phase-1, 5 = just delivered.
  logic [15:0] m_lfsr;
  int          m_phase;
  bit          m_pend;
  logic [7:0]  m_slot[4];
  logic [7:0]  m_fruit[4];

  fruit_random_gen dut (
    .clk       (clk),
    .resetN    (resetN),
    .req       (req),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .fruit1_t  (fruit1_t),
    .fruit2_t  (fruit2_t),
    .fruit3_t  (fruit3_t),
    .fruit4_t  (fruit4_t),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_phase = 0;
    m_pend  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_slot[i]  = 8'h00;
      m_fruit[i] = 8'h00;
    end
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    if (m_phase >= 1 && m_phase <= 4) begin
      m_slot[m_phase-1] = m_lfsr[7:0];
      if (m_phase == 4) begin
        for (int i = 0; i < 4; i++) m_fruit[i] = m_slot[i];
      end
    end
    if (m_phase == 0) begin
      if (req || m_pend) begin
        m_phase = 1;
        m_pend  = 1'b0;
      end
    end else begin
      if (req) m_pend = 1'b1;
      m_phase = (m_phase == 5) ? 0 : m_phase + 1;
    end
    if (seed_load) m_lfsr = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
    else           m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic check_all();
    chk("lfsr",   dut.lfsr_q, m_lfsr);
    chk("fruit1", 16'(fruit1_t), 16'(m_fruit[0]));
    chk("fruit2", 16'(fruit2_t), 16'(m_fruit[1]));
    chk("fruit3", 16'(fruit3_t), 16'(m_fruit[2]));
    chk("fruit4", 16'(fruit4_t), 16'(m_fruit[3]));
    chk("valid",  16'(valid), 16'(m_phase == 5));
    chk("busy",   16'(busy),  16'(m_phase >= 1 && m_phase <= 4));
    chk("valid_busy_excl", 16'(valid & busy), 16'h0000);
  endtask

  task automatic step(input bit r, input bit sl, input logic [15:0] si);
    req       = r;
    seed_load = sl;
    seed_in   = si;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int vcount;
    resetN    = 1'b1;
    req       = 1'b0;
    seed_load = 1'b0;
    seed_in   = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_lfsr", dut.lfsr_q, 16'hACE1);
    resetN = 1'b0;

    // First edge after release advances the default seed.
    step(0, 0, 16'h0000);
    chk("first_adv", dut.lfsr_q, 16'h59C3);
    step(0, 0, 16'h0000);

    // Zero reseed maps to 1, then a single req fills 02,04,08,10.
    step(0, 1, 16'h0000);
    chk("zero_seed", dut.lfsr_q, 16'h0001);
    step(1, 0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk("busy_fill", 16'(busy), 16'h0001);
      step(0, 0, 16'h0000);
    end
    chk("f1_known", 16'(fruit1_t), 16'h0002);
    chk("f2_known", 16'(fruit2_t), 16'h0004);
    chk("f3_known", 16'(fruit3_t), 16'h0008);
    chk("f4_known", 16'(fruit4_t), 16'h0010);
    chk("valid_known", 16'(valid), 16'h0001);
    step(0, 0, 16'h0000);
    chk("valid_one_cycle", 16'(valid), 16'h0000);

    // req held high: back-to-back fills every 6 cycles.
    vcount = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 16'($urandom));
      if (valid) vcount++;
    end
    chk("held_req_valids", 16'(vcount), 16'd4);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0000);

    // Three reqs inside one fill collapse into a single extra fill.
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 16'h0000);
      if (valid) vcount++;
    end
    chk("extra_fills", 16'(vcount), 16'd1);
    chk("idle_busy", 16'(busy), 16'h0000);

    // Reset during the third fill cycle discards the partial set.
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    #2;
    resetN = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetN = 1'b0;
    step(1, 0, 16'h0000);
    for (int i = 0; i < 6; i++) step(0, 0, 16'h0000);

    // Zero reseed mid-fill keeps filling from the reseeded sequence.
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 1, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    chk("reseed_f3", 16'(fruit3_t), 16'h0001);
    chk("reseed_f4", 16'(fruit4_t), 16'h0002);
    chk("reseed_valid", 16'(valid), 16'h0001);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fruit_random_gen.md
FRUIT_RANDOM_GEN -- requirements
Module: fruit_random_gen

Interface
REQ-001 Parameter SEED, default 16'hACE1, LFSR value loaded at reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 resetN  input  1  asynchronous, active-high reset (high = reset asserted).
REQ-004 req  input  1  request for a new set of four fruit values; sampled each rising edge.
REQ-005 seed_load  input  1  when high, LFSR is loaded from seed_in at the next rising edge.
REQ-006 seed_in  input  16  reseed value used with seed_load.
REQ-007 fruit1_t, fruit2_t, fruit3_t, fruit4_t  output  8 each  random fruit bytes for the fruit-type decoder, registered.
REQ-008 valid  output  1  one-cycle pulse: all four fruit outputs have just been updated.
REQ-009 busy  output  1  high while a fill is in progress (FILL state).

Function
REQ-010 The LFSR SHALL be 16 bits, Fibonacci form: fb = b15^b13^b12^b10, next = {lfsr[14:0], fb}.
REQ-011 The LFSR SHALL advance on every rising edge not in reset, independent of FSM state.
REQ-012 seed_load SHALL take priority over advance: lfsr <= seed_in, or 16'h0001 if seed_in == 0.
REQ-013 If SEED == 0, the reset value SHALL be 16'h0001 (no lock-up state is ever reachable).
REQ-014 The FSM SHALL have states IDLE, FILL, DONE; reset state IDLE.
REQ-015 IDLE: req=1 or pending=1 -> FILL, slot counter = 0, pending cleared; otherwise stay.
REQ-016 FILL: each edge captures the current lfsr[7:0] (the value before that edge's advance) into shadow slot[counter], then counter+1.
REQ-017 FILL: on the edge capturing slot 3, all four fruit outputs SHALL load together (slots 0-2 from shadow, slot 3 direct), and the FSM goes to DONE.
REQ-018 Fruit outputs SHALL change only on that edge; the consumer never sees a partially updated set.
REQ-019 DONE: valid=1 for exactly this one cycle; next state IDLE.
REQ-020 busy SHALL be 1 exactly in FILL (4 cycles per fill); valid and busy are never both 1.
REQ-021 req sampled high in FILL or DONE SHALL set a single pending flag (multiple requests collapse to one); pending starts the next fill from IDLE.
REQ-022 Fill-to-fill latency with req held high SHALL be 6 cycles (IDLE, 4 x FILL, DONE).
REQ-023 seed_load during FILL SHALL NOT abort the fill; remaining slots capture the reseeded sequence.
REQ-024 Fruit outputs SHALL hold their last values indefinitely while no fill completes.

Reset
REQ-025 While resetN=1: lfsr=SEED (or 0001), state=IDLE, counter=0, pending=0, shadow slots=0, fruit1_t..fruit4_t=8'h00, valid=0, busy=0.
REQ-026 Reset asserted mid-FILL SHALL discard the partial fill; outputs read 0 and no valid is produced.
REQ-027 After release, the first edge advances the LFSR (ACE1 -> 59C3 for default SEED).

Verification
REQ-028 Default SEED, release reset, no inputs -> lfsr 16'hACE1 then 16'h59C3 on the first edge; outputs 0, valid 0.
REQ-029 seed_load=1, seed_in=0 at edge 0 (lfsr=0001); req=1 at edge 1 only -> busy on edges 2-5; after edge 5 fruit1..4 = 02,04,08,10, with valid=1 for exactly that cycle.
REQ-030 req held high continuously -> valid pulses every 6 cycles; outputs are stable between pulses.
REQ-031 req pulsed 3 times during one FILL -> exactly one extra fill follows, then IDLE with busy=0.
REQ-032 resetN asserted at the third FILL cycle -> outputs 00, busy 0, no valid; a fresh req after release completes normally.
REQ-033 seed_load with seed_in=16'h0000 during FILL -> lfsr=0001, no lock-up; remaining slots take 01, 02, ... per REQ-016.
